// File: rtl/mem_stall_resp.sv
// rtl/mem_stall_resp.sv - fixed-latency stalling word memory responder
// One request in flight; Stall holds the requester until the Done cycle.
module mem_stall_resp #(
    parameter int LATENCY = 3,
    parameter int AW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Stall,
    output logic        Done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int         DEPTH = 1 << AW;
    localparam logic [3:0] LOAD  = 4'(LATENCY - 1);

    state_t          state, state_next;
    logic [3:0]      cnt, cnt_next;
    logic            op_wr;
    logic [AW-1:0]   idx;
    logic [15:0]     wdata;
    logic [15:0]     mem [DEPTH];
    logic            req, legal, accept;

    generate
        if (AW < 15) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^Addr[15:AW+1];
        end
    endgenerate

    always_comb begin
        req    = Rd | Wr;
        legal  = (Rd ^ Wr) & ~Addr[0];
        accept = (state == IDLE) & legal;
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (legal) begin
                    cnt_next   = LOAD;
                    state_next = (LATENCY == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                // Counter reaches zero on the same edge that enters DONE.
                cnt_next = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                cnt_next   = 4'd0;
                state_next = IDLE;
            end
            default: begin
                cnt_next   = 4'd0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            err   <= (state == IDLE) & req & ~legal;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            op_wr <= Wr;
            idx   <= Addr[AW:1];
            wdata <= DataIn;
        end
    end

    // Storage is never reset; an aborted write simply never reaches this commit.
    always_ff @(posedge clk) begin
        if (!rst && state == DONE && op_wr) begin
            mem[idx] <= wdata;
        end
    end

    always_comb begin
        Stall   = ~rst & (accept | (state == BUSY));
        Done    = (state == DONE);
        DataOut = (state == DONE && !op_wr) ? mem[idx] : 16'h0000;
    end

endmodule

// File: tb/tb_mem_stall_resp.sv
// tb/tb_mem_stall_resp.sv - directed bench for mem_stall_resp at LATENCY 3 and 1
// A cycle-timeline model predicts every output each cycle; literals pin key cases.
module tb_mem_stall_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst, rd, wr, stall, done, err;
    logic [15:0] addr [2];
    logic [15:0] din  [2];
    logic [15:0] dout [2];

    mem_stall_resp #(.LATENCY(3), .AW(8)) u_lat3 (
        .clk(clk), .rst(rst[0]), .Addr(addr[0]), .DataIn(din[0]), .Rd(rd[0]), .Wr(wr[0]),
        .DataOut(dout[0]), .Stall(stall[0]), .Done(done[0]), .err(err[0])
    );

    mem_stall_resp #(.LATENCY(1), .AW(8)) u_lat1 (
        .clk(clk), .rst(rst[1]), .Addr(addr[1]), .DataIn(din[1]), .Rd(rd[1]), .Wr(wr[1]),
        .DataOut(dout[1]), .Stall(stall[1]), .Done(done[1]), .err(err[1])
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
        end
    endtask

    // Model: an accepted request at cycle T owns cycles T..T+lat; idle again afterwards.
    int          cyc = 0;
    int          m_acc    [2] = '{-1, -1};
    int          m_err_at [2] = '{-1, -1};
    bit          m_valid  [2] = '{0, 0};
    bit          m_wr     [2];
    int          m_idx    [2];
    logic [15:0] m_data   [2];
    logic [15:0] m_mem    [2][256];

    int          stall_cnt [2], done_cnt [2], err_cnt [2];
    int          first_stall [2], first_done [2], last_done [2];
    logic [15:0] last_dout [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int lat, ix;
            bit idle, legal, illegal, accept, e_stall, e_done, e_err;
            logic [15:0] e_dout;
            lat     = (d == 0) ? 3 : 1;
            ix      = int'(addr[d][8:1]);
            idle    = (m_acc[d] < 0) || (cyc > m_acc[d] + lat);
            legal   = (rd[d] ^ wr[d]) && !addr[d][0];
            illegal = (rd[d] | wr[d]) && !legal;
            accept  = idle && legal && !rst[d];
            e_stall = !rst[d] && (accept || (m_acc[d] >= 0 && cyc > m_acc[d] && cyc < m_acc[d] + lat));
            e_done  = (m_acc[d] >= 0) && (cyc == m_acc[d] + lat);
            e_dout  = (e_done && !m_wr[d]) ? m_mem[d][m_idx[d]] : 16'h0000;
            e_err   = (cyc == m_err_at[d]);

            if (rst[d]) chk("stall_in_reset", d, stall[d], 0);
            if (m_valid[d]) begin
                if (!rst[d]) chk("stall", d, stall[d], e_stall);
                chk("done", d, done[d], e_done);
                chk("dataout", d, dout[d], e_dout);
                chk("err", d, err[d], e_err);
            end

            stall_cnt[d] += int'(stall[d]);
            err_cnt[d]   += int'(err[d]);
            if (stall[d] && first_stall[d] < 0) first_stall[d] = cyc;
            if (done[d]) begin
                done_cnt[d]++;
                if (first_done[d] < 0) first_done[d] = cyc;
                last_done[d] = cyc;
                last_dout[d] = dout[d];
            end

            if (rst[d]) begin
                m_acc[d]    = -1;
                m_err_at[d] = -1;
                m_valid[d]  = 1'b1;
            end else begin
                if (e_done && m_wr[d]) m_mem[d][m_idx[d]] = m_data[d];
                if (accept) begin
                    m_acc[d]  = cyc;
                    m_wr[d]   = wr[d];
                    m_idx[d]  = ix;
                    m_data[d] = din[d];
                end
                if (idle && illegal) m_err_at[d] = cyc + 1;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in(input int d);
        rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = 16'h0000; din[d] = 16'h0000;
    endtask

    task automatic clr(input int d);
        stall_cnt[d] = 0; done_cnt[d] = 0; err_cnt[d] = 0;
        first_stall[d] = -1; first_done[d] = -1; last_done[d] = -1; last_dout[d] = 16'h0000;
    endtask

    task automatic wait_done(input int d, input int n);
        int i;
        i = 0;
        while (done_cnt[d] < n && i < 40) begin
            step();
            i++;
        end
        if (done_cnt[d] < n) chk("done_timeout", d, done_cnt[d], n);
    endtask

    // Hold the request until Done; with hold, keep it one more cycle so it is re-accepted.
    task automatic xfer(input int d, input bit r, input bit w, input logic [15:0] a,
                        input logic [15:0] di, input bit hold);
        clr(d);
        addr[d] = a; din[d] = di; rd[d] = r; wr[d] = w;
        wait_done(d, 1);
        if (hold) step();
        idle_in(d);
        if (hold) wait_done(d, 2);
        step();
    endtask

    task automatic bad(input int d, input bit r, input bit w, input logic [15:0] a);
        clr(d);
        addr[d] = a; din[d] = 16'h9999; rd[d] = r; wr[d] = w;
        step();
        idle_in(d);
        step();
        step();
        chk("bad_err_pulses", d, err_cnt[d], 1);
        chk("bad_stall", d, stall_cnt[d], 0);
        chk("bad_done", d, done_cnt[d], 0);
    endtask

    logic [15:0] wa [4] = '{16'h0100, 16'h01FE, 16'h0302, 16'h0040};
    logic [15:0] ra [4] = '{16'h0100, 16'h01FE, 16'h0102, 16'h0040};
    logic [15:0] wd [4] = '{16'hA5A5, 16'h0F0F, 16'h7E57, 16'hFFFF};

    initial begin
        rst = 2'b11;
        for (int d = 0; d < 2; d++) begin
            idle_in(d);
            clr(d);
        end
        step();
        step();
        rst = 2'b00;
        for (int d = 0; d < 2; d++) begin
            chk("reset_done", d, done[d], 0);
            chk("reset_err", d, err[d], 0);
            chk("reset_dataout", d, dout[d], 0);
            chk("reset_stall", d, stall[d], 0);
        end
        step();

        xfer(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
        chk("wr_stall_cycles", 0, stall_cnt[0], 3);
        chk("wr_latency", 0, last_done[0] - first_stall[0], 3);
        chk("wr_dataout", 0, last_dout[0], 16'h0000);
        xfer(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        chk("rd_data", 0, last_dout[0], 16'hBEEF);
        chk("rd_latency", 0, last_done[0] - first_stall[0], 3);

        bad(0, 1'b1, 1'b0, 16'h0011);

        xfer(0, 1'b0, 1'b1, 16'h0004, 16'h1111, 1'b0);
        bad(0, 1'b1, 1'b1, 16'h0004);
        xfer(0, 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);
        chk("rdwr_no_write", 0, last_dout[0], 16'h1111);

        xfer(0, 1'b0, 1'b1, 16'h0020, 16'h5A5A, 1'b0);
        clr(0);
        addr[0] = 16'h0020; din[0] = 16'h1234; wr[0] = 1'b1;
        step();
        idle_in(0);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        step();
        step();
        chk("abort_no_done", 0, done_cnt[0], 0);
        xfer(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
        chk("abort_keeps_old", 0, last_dout[0], 16'h5A5A);

        xfer(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
        chk("hold_done_pulses", 0, done_cnt[0], 2);
        chk("hold_stall_cycles", 0, stall_cnt[0], 6);
        chk("hold_gap", 0, last_done[0] - first_done[0], 4);
        chk("hold_data", 0, last_dout[0], 16'hBEEF);

        xfer(1, 1'b0, 1'b1, 16'h0200, 16'hCAFE, 1'b0);
        chk("l1_wr_stall", 1, stall_cnt[1], 1);
        chk("l1_wr_latency", 1, last_done[1] - first_stall[1], 1);
        xfer(1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        chk("l1_alias_data", 1, last_dout[1], 16'hCAFE);
        chk("l1_rd_stall", 1, stall_cnt[1], 1);
        chk("l1_rd_latency", 1, last_done[1] - first_stall[1], 1);
        xfer(1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1);
        chk("l1_hold_pulses", 1, done_cnt[1], 2);
        chk("l1_hold_gap", 1, last_done[1] - first_done[1], 2);
        bad(1, 1'b0, 1'b1, 16'h0003);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) xfer(d, 1'b0, 1'b1, wa[i], wd[i], 1'b0);
            for (int i = 0; i < 4; i++) begin
                xfer(d, 1'b1, 1'b0, ra[i], 16'h0000, 1'b0);
                chk("table_read", d, last_dout[d], wd[i]);
            end
        end

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
